// File: rtl/cla_pkg.sv
// ---------------------------------------------------------------------------
// cla_pkg
// Shared constants and types for the sequential carry-lookahead adder.
//   SLICE_W : width of the single lookahead slice reused every cycle
//   state_t : sequencing states of cla_add_seq
// ---------------------------------------------------------------------------
package cla_pkg;

    localparam int SLICE_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cla_slice5.sv
// ---------------------------------------------------------------------------
// cla_slice5
// Purely combinational 5-bit carry-lookahead slice.
// Ports:
//   a, b : 5-bit operand slices
//   cin  : carry into bit 0 of the slice
//   sum  : 5-bit slice sum
//   c4   : carry into bit 4 (needed for overflow on the top slice)
//   c5   : carry out of bit 4
// ---------------------------------------------------------------------------
module cla_slice5
    import cla_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               c4,
    output logic               c5
);

    logic [SLICE_W-1:0] g_bar;
    logic [SLICE_W-1:0] g;
    logic [SLICE_W-1:0] p;
    logic               c1;
    logic               c2;
    logic               c3;

    // Generate is kept in inverted (NAND) form as the slice's native output;
    // the lookahead equations below use its complement.
    assign g_bar = ~(a & b);
    assign g     = ~g_bar;
    assign p     = a ^ b;

    // Every carry is a flat sum of products of g, p and cin, so no carry
    // depends on another carry (true lookahead, no ripple).
    assign c1 = g[0]
              | (p[0] & cin);
    assign c2 = g[1]
              | (p[1] & g[0])
              | (p[1] & p[0] & cin);
    assign c3 = g[2]
              | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
    assign c4 = g[3]
              | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);
    assign c5 = g[4]
              | (p[4] & g[3])
              | (p[4] & p[3] & g[2])
              | (p[4] & p[3] & p[2] & g[1])
              | (p[4] & p[3] & p[2] & p[1] & g[0])
              | (p[4] & p[3] & p[2] & p[1] & p[0] & cin);

    assign sum = p ^ {c4, c3, c2, c1, cin};

endmodule

// File: rtl/cla_add_seq.sv
// ---------------------------------------------------------------------------
// cla_add_seq
// Sequential W-bit adder (W = 5*NUM_CHUNKS) that pushes one 5-bit chunk per
// cycle through a single cla_slice5, least significant chunk first.
// Ports:
//   clk, rst          : clock and synchronous active-high reset
//   in_valid/in_ready : request handshake; a, b, cin sampled on acceptance
//   out_valid/out_ready : result handshake; sum, cout, ovf held until taken
//   sum  : a+b+cin modulo 2^W
//   cout : carry out of bit W-1
//   ovf  : two's-complement overflow (carry into MSB xor carry out)
// ---------------------------------------------------------------------------
module cla_add_seq
    import cla_pkg::*;
#(
    parameter int NUM_CHUNKS = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [SLICE_W*NUM_CHUNKS-1:0]   a,
    input  logic [SLICE_W*NUM_CHUNKS-1:0]   b,
    input  logic                            cin,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [SLICE_W*NUM_CHUNKS-1:0]   sum,
    output logic                            cout,
    output logic                            ovf
);

    localparam int W     = SLICE_W * NUM_CHUNKS;
    localparam int IDX_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    state_t              state;
    state_t              next_state;
    logic [IDX_W-1:0]    idx;
    logic [W-1:0]        a_reg;
    logic [W-1:0]        b_reg;
    logic                carry;
    logic [W-1:0]        sum_reg;
    logic                cout_reg;
    logic                ovf_reg;

    int                  chunk_base;
    logic [SLICE_W-1:0]  slice_sum;
    logic                slice_c4;
    logic                slice_c5;

    assign chunk_base = int'(idx) * SLICE_W;

    // The one and only adder: it always looks at the chunk selected by idx
    // together with the carry left over from the previous chunk.
    cla_slice5 u_slice (
        .a   (a_reg[chunk_base +: SLICE_W]),
        .b   (b_reg[chunk_base +: SLICE_W]),
        .cin (carry),
        .sum (slice_sum),
        .c4  (slice_c4),
        .c5  (slice_c5)
    );

    // State register; reset wins over any handshake on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake outputs, decoded purely from the state.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                if (idx == LAST_IDX) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Operand capture, chunk sequencing and result assembly. The carry is
    // seeded from cin only on acceptance, so nothing leaks between
    // operations. The result registers are left untouched in DONE, which
    // keeps the outputs stable while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx      <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            carry    <= 1'b0;
            sum_reg  <= '0;
            cout_reg <= 1'b0;
            ovf_reg  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg    <= a;
                        b_reg    <= b;
                        carry    <= cin;
                        idx      <= '0;
                        sum_reg  <= '0;
                        cout_reg <= 1'b0;
                        ovf_reg  <= 1'b0;
                    end
                end
                RUN: begin
                    sum_reg[chunk_base +: SLICE_W] <= slice_sum;
                    carry                          <= slice_c5;
                    if (idx == LAST_IDX) begin
                        cout_reg <= slice_c5;
                        ovf_reg  <= slice_c4 ^ slice_c5;
                        idx      <= '0;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sum  = sum_reg;
    assign cout = cout_reg;
    assign ovf  = ovf_reg;

endmodule

// File: tb/tb_cla_add_seq.sv
// ---------------------------------------------------------------------------
// tb_cla_add_seq
// Self-checking bench for cla_add_seq with NUM_CHUNKS = 4 (W = 20).
// Expected results come from plain integer addition of the operands.
// ---------------------------------------------------------------------------
module tb_cla_add_seq;

    localparam int NUM_CHUNKS = 4;
    localparam int W          = 5 * NUM_CHUNKS;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  sum;
    logic          cout;
    logic          ovf;

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 clk = ~clk;

    cla_add_seq #(.NUM_CHUNKS(NUM_CHUNKS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    // Reference: returns {ovf, cout, sum} from whole-word arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] x,
                                           input logic [W-1:0] y,
                                           input logic ci);
        logic [W:0]   full;
        logic [W-1:0] s;
        logic         o;
        full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        s    = full[W-1:0];
        o    = (x[W-1] == y[W-1]) && (s[W-1] != x[W-1]);
        return {o, full[W], s};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, then wait (bounded) for out_valid; lat counts edges
    // after the accepting edge.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic ci, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        a        = x;
        b        = y;
        cin      = ci;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat      = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
    endtask

    task automatic retire();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        a = 20'h12345; b = 20'h11111; cin = 1'b1;
        tick();
        tick();
        n_compared++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== '0 ||
            cout !== 1'b0 || ovf !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_state: in_ready=%b out_valid=%b sum=%h cout=%b ovf=%b, required 1 0 00000 0 0",
                     in_ready, out_valid, sum, cout, ovf);
        end
        in_valid = 1'b0;
        rst      = 1'b0;
        tick();
        n_compared++;
        if (in_ready !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL reset_priority: in_ready=%b, required 1", in_ready);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] va [4];
        logic [W-1:0] vb [4];
        logic         vc [4];
        logic [W-1:0] es [4];
        logic         eco [4];
        logic         eov [4];
        int           lat;
        va[0] = 20'hFFFFF; vb[0] = 20'h00001; vc[0] = 1'b0; es[0] = 20'h00000; eco[0] = 1'b1; eov[0] = 1'b0;
        va[1] = 20'h7FFFF; vb[1] = 20'h00001; vc[1] = 1'b0; es[1] = 20'h80000; eco[1] = 1'b0; eov[1] = 1'b1;
        va[2] = 20'h80000; vb[2] = 20'h80000; vc[2] = 1'b0; es[2] = 20'h00000; eco[2] = 1'b1; eov[2] = 1'b1;
        va[3] = 20'h12345; vb[3] = 20'h0ABCD; vc[3] = 1'b1; es[3] = 20'h1CF13; eco[3] = 1'b0; eov[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            run_op(va[i], vb[i], vc[i], lat);
            n_compared++;
            if (lat !== NUM_CHUNKS) begin
                n_mismatched++;
                $display("[TB] FAIL directed_latency[%0d]: got %0d, required %0d", i, lat, NUM_CHUNKS);
            end
            n_compared++;
            if (sum !== es[i] || cout !== eco[i] || ovf !== eov[i]) begin
                n_mismatched++;
                $display("[TB] FAIL directed_result[%0d]: sum=%h cout=%b ovf=%b, required %h %b %b",
                         i, sum, cout, ovf, es[i], eco[i], eov[i]);
            end
            retire();
            n_compared++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_mismatched++;
                $display("[TB] FAIL directed_release[%0d]: out_valid=%b in_ready=%b, required 0 1",
                         i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_stall();
        logic [W+1:0] exp;
        int           lat;
        int           bad;
        exp = model(20'h5A5A5, 20'hC3C3C, 1'b1);
        run_op(20'h5A5A5, 20'hC3C3C, 1'b1, lat);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = ~in_valid;
            a        = W'($urandom);
            b        = W'($urandom);
            cin      = 1'($urandom);
            tick();
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== exp[W-1:0] ||
                cout !== exp[W] || ovf !== exp[W+1]) begin
                bad++;
            end
        end
        n_compared++;
        if (bad != 0) begin
            n_mismatched++;
            $display("[TB] FAIL stall_hold: %0d unstable cycles, required 0", bad);
        end
        in_valid = 1'b0;
        retire();
        tick();
        n_compared++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL stall_no_accept: in_ready=%b out_valid=%b, required 1 0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_reset_midrun();
        logic [W+1:0] exp;
        int           lat;
        int           bad;
        a = 20'hABCDE; b = 20'h13579; cin = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_compared++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== '0 ||
            cout !== 1'b0 || ovf !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL midrun_reset: in_ready=%b out_valid=%b sum=%h cout=%b ovf=%b, required 1 0 00000 0 0",
                     in_ready, out_valid, sum, cout, ovf);
        end
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid !== 1'b0) bad++;
        end
        n_compared++;
        if (bad != 0) begin
            n_mismatched++;
            $display("[TB] FAIL midrun_ghost: out_valid high %0d cycles, required 0", bad);
        end
        exp = model(20'h0F0F0, 20'h70F0F, 1'b0);
        run_op(20'h0F0F0, 20'h70F0F, 1'b0, lat);
        n_compared++;
        if (sum !== exp[W-1:0] || cout !== exp[W] || ovf !== exp[W+1]) begin
            n_mismatched++;
            $display("[TB] FAIL midrun_recover: sum=%h cout=%b ovf=%b, required %h %b %b",
                     sum, cout, ovf, exp[W-1:0], exp[W], exp[W+1]);
        end
        retire();
    endtask

    task automatic test_back_to_back();
        logic [W+1:0] q[$];
        logic [W+1:0] exp;
        int           cycle;
        int           accepts;
        int           results;
        int           last_acc;
        cycle = 0; accepts = 0; results = 0; last_acc = -1;
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        in_valid = 1'b1; out_ready = 1'b1;
        while ((accepts < 100 || results < accepts) && cycle < 2000) begin
            if (out_valid) begin
                n_compared++;
                if (q.size() == 0) begin
                    n_mismatched++;
                    $display("[TB] FAIL b2b_unexpected: result %h with no request pending", sum);
                end else begin
                    exp = q.pop_front();
                    if (sum !== exp[W-1:0] || cout !== exp[W] || ovf !== exp[W+1]) begin
                        n_mismatched++;
                        $display("[TB] FAIL b2b_result[%0d]: sum=%h cout=%b ovf=%b, required %h %b %b",
                                 results, sum, cout, ovf, exp[W-1:0], exp[W], exp[W+1]);
                    end
                end
                results++;
            end
            if (in_valid && in_ready) begin
                q.push_back(model(a, b, cin));
                if (last_acc >= 0) begin
                    n_compared++;
                    if (cycle - last_acc != NUM_CHUNKS + 2) begin
                        n_mismatched++;
                        $display("[TB] FAIL b2b_spacing[%0d]: got %0d, required %0d",
                                 accepts, cycle - last_acc, NUM_CHUNKS + 2);
                    end
                end
                last_acc = cycle;
                accepts++;
            end
            tick();
            cycle++;
            if (accepts >= 100) in_valid = 1'b0;
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        end
        n_compared++;
        if (results != 100 || accepts != 100) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_count: accepts=%0d results=%0d, required 100 100", accepts, results);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_reset_midrun();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
